decode_grf_scoreboard: RTL and testbench
========================================

// Module: decode_grf_scoreboard
// PURPOSE
//   Decode-stage register file with NRD read ports, write-through bypass and a per-register
//   Tnew scoreboard that raises stall when any source operand is not ready by its Tuse.
//   Sits in D between IF/ID and ID/EX; writeback port driven from W; stall feeds PC/IF-ID enable.
// PARAMETERS
//   DATA_W   32  register width
//   ADDR_W   5   register index width; 2**ADDR_W registers, register 0 reads 0 and ignores writes
//   NRD      2   number of read ports
//   TNEW_W   2   width of Tnew/Tuse and of each scoreboard counter
// PORTS
//   clk          in   1              rising-edge clock
//   reset        in   1              synchronous, active-low reset (0 = reset)
//   rd_addr      in   NRD*ADDR_W     read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_tuse      in   NRD*TNEW_W     cycles until port i value is consumed
//   rd_data      out  NRD*DATA_W     read data, port i at [i*DATA_W +: DATA_W]
//   issue_valid  in   1              instruction in D leaves D this cycle (if not stalled)
//   issue_dst    in   ADDR_W         destination register of issuing instruction
//   issue_tnew   in   TNEW_W         cycles until its result is forwardable
//   stall        out  1              hold D and IF this cycle
//   wb_we        in   1              writeback enable
//   wb_addr      in   ADDR_W         writeback address
//   wb_data      in   DATA_W         writeback data
//   wb_pc        in   32             PC of writeback instruction (trace only)
//   stall_cnt    out  32             saturating count of stalled cycles
// BEHAVIOUR
//   - Reset (reset==0 at edge): all registers 0, all counters 0, stall_cnt 0; stall then reads 0.
//     Reset mid-operation discards all pending state at that edge; no partial writes survive.
//   - Write: at edge, if wb_we && wb_addr!=0, reg[wb_addr] <= wb_data. Writes to 0 dropped.
//   - Read (combinational, 0 latency): rd_addr==0 -> 0; else if wb_we && wb_addr==rd_addr ->
//     wb_data (bypass); else reg[rd_addr]. All NRD ports independent, same address allowed.
//   - Scoreboard cnt[r], TNEW_W bits, cnt[0] always 0. Each edge, per r!=0:
//       issue_valid && !stall && issue_dst==r -> cnt[r] <= issue_tnew (overrides pending value
//       and the decrement; later writer wins); else cnt[r]!=0 -> cnt[r]-1; else hold 0.
//   - stall = OR over i of (rd_addr_i!=0 && cnt[rd_addr_i] > rd_tuse_i). Combinational.
//     issue_tnew==0 or issue_dst==0 creates no hazard. Stall blocks the scoreboard update.
//   - stall_cnt increments at each edge where stall==1, saturates at 32'hFFFF_FFFF.
//   - Writeback does not clear counters; counters alone define readiness.
// CONFIGURATION
//   GRF_TRACE_EN defined: on every accepted write (wb_we, wb_addr!=0, not in reset)
//     $display("@%h: $%d <= %h", wb_pc, wb_addr, wb_data) at the write edge.
//   Undefined: no display statements; wb_pc unused; identical functional behaviour.
// STRUCTURE
//   Shared header/package: DATA_W/ADDR_W/TNEW_W defaults, REG_ZERO constant, TNEW/TUSE encodings.
//   One sub-module: grf_bank (storage, write port, NRD bypassed read ports, trace hook).
//   Scoreboard counters, stall reduction and stall_cnt live in the top module.
// TESTING
//   1 reset=0 two cycles, then read ports 5,31 -> rd_data 0, stall 0, stall_cnt 0.
//   2 wb_we=1 addr 8 data 32'h1234_5678, rd_addr0=8 same cycle -> rd_data0=32'h1234_5678
//     (bypass); next cycle without wb -> still 32'h1234_5678; write to 0 -> reads 0.
//   3 issue dst=9 tnew=2; next cycle rd_addr0=9 tuse=0 -> stall 1 for 2 cycles (cnt 2,1),
//     then 0; stall_cnt=2. Same with tuse=1 -> stall 1 cycle only.
//   4 issue dst=9 tnew=2, next cycle stalled issue dst=9 tnew=1 -> ignored, cnt decrements;
//     unstalled re-issue dst=9 tnew=1 with cnt=2 -> cnt becomes 1.
//   5 NRD=3 build: ports 0/1/2 read 9/9/10, only 10 pending with tnew 1 > tuse 0 -> stall 1.
//   6 pending cnt[9]=2, assert reset=0 -> next cycle cnt 0, stall 0, stall_cnt 0, regs 0.

Source files
------------

// File: rtl/decode_grf_scoreboard_pkg.sv
// Shared constants and Tnew/Tuse encodings for the decode-stage register file and scoreboard.
package decode_grf_scoreboard_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NRD_DEF    = 2;
    localparam int TNEW_W_DEF = 2;

    // Register 0 is hardwired: reads return 0, writes and issues to it are ignored
    localparam int REG_ZERO = 0;

    // Tnew/Tuse encoding at the default width: cycles until produced/consumed
    typedef enum logic [TNEW_W_DEF-1:0] {
        T_NOW = 2'd0,
        T_1   = 2'd1,
        T_2   = 2'd2,
        T_3   = 2'd3
    } tcycles_e;

endpackage

// File: rtl/decode_grf_scoreboard_if.sv
// Decode-stage bundle: read ports, issue request, stall and writeback between pipeline and GRF.
interface decode_grf_scoreboard_if
    import decode_grf_scoreboard_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NRD    = NRD_DEF,
    parameter int TNEW_W = TNEW_W_DEF
) ();

    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*TNEW_W-1:0] rd_tuse;
    logic [NRD*DATA_W-1:0] rd_data;
    logic                  issue_valid;
    logic [ADDR_W-1:0]     issue_dst;
    logic [TNEW_W-1:0]     issue_tnew;
    logic                  stall;
    logic                  wb_we;
    logic [ADDR_W-1:0]     wb_addr;
    logic [DATA_W-1:0]     wb_data;
    logic [31:0]           wb_pc;

    // Pipeline side
    modport master (
        output rd_addr, rd_tuse, issue_valid, issue_dst, issue_tnew,
        output wb_we, wb_addr, wb_data, wb_pc,
        input  rd_data, stall
    );

    // Register file / scoreboard side
    modport slave (
        input  rd_addr, rd_tuse, issue_valid, issue_dst, issue_tnew,
        input  wb_we, wb_addr, wb_data, wb_pc,
        output rd_data, stall
    );

endinterface

// File: rtl/decode_grf_scoreboard_grf_bank.sv
// Register storage with one write port and NRD write-through bypassed read ports.
// Define GRF_TRACE_EN to print every accepted write with its PC.
module grf_bank
    import decode_grf_scoreboard_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NRD    = NRD_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [31:0]           wpc,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic              wr_ok;

    assign wr_ok = we && (waddr != ADDR_W'(REG_ZERO));

    // NOTE: the array is reset because a mid-run reset must leave every register at 0;
    // this keeps it in flops rather than a RAM macro, which a register file wants anyway.
    always_ff @(posedge clk) begin
        if (!reset) begin
            regs <= '{default: '0};
        end else if (wr_ok) begin
            // NOTE: non-blocking so reads in the same cycle see the old value; the bypass
            // below supplies the new one combinationally.
            regs[waddr] <= wdata;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = raddr[i*ADDR_W +: ADDR_W];
        assign rdata[i*DATA_W +: DATA_W] =
            (a == ADDR_W'(REG_ZERO)) ? '0     :
            (we && waddr == a)       ? wdata  :
                                       regs[a];
    end

`ifdef GRF_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset && wr_ok) begin
            $display("@%h: $%d <= %h", wpc, waddr, wdata);
        end
    end
`else
    logic unused_wpc;
    assign unused_wpc = ^wpc;
`endif

endmodule

// File: rtl/decode_grf_scoreboard.sv
// Decode-stage GRF with per-register Tnew scoreboard, stall generation and stall counter.
// Define GRF_TRACE_EN to enable the writeback trace in grf_bank.
module decode_grf_scoreboard
    import decode_grf_scoreboard_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NRD    = NRD_DEF,
    parameter int TNEW_W = TNEW_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    decode_grf_scoreboard_if.slave   bus,
    output logic [31:0]              stall_cnt
);

    localparam int NREG = 2 ** ADDR_W;

    logic [TNEW_W-1:0] cnt [NREG];
    logic              stall;
    logic              issue_ok;

    grf_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NRD    (NRD)
    ) u_bank (
        .clk   (clk),
        .reset (reset),
        .we    (bus.wb_we),
        .waddr (bus.wb_addr),
        .wdata (bus.wb_data),
        .wpc   (bus.wb_pc),
        .raddr (bus.rd_addr),
        .rdata (bus.rd_data)
    );

    // A port hazards when its producer is still further away than its consumer
    always_comb begin
        // NOTE: default first so no path leaves stall unassigned and infers a latch.
        stall = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            if (bus.rd_addr[i*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO) &&
                cnt[bus.rd_addr[i*ADDR_W +: ADDR_W]] > bus.rd_tuse[i*TNEW_W +: TNEW_W]) begin
                stall = 1'b1;
            end
        end
    end

    assign bus.stall = stall;
    assign issue_ok  = bus.issue_valid && !stall;

    // cnt[0] is only ever cleared, so register 0 never hazards
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= '{default: '0};
            stall_cnt <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (issue_ok && bus.issue_dst == ADDR_W'(r)) begin
                    cnt[r] <= bus.issue_tnew;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
            if (stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_decode_grf_scoreboard.sv
// Directed self-checking bench for decode_grf_scoreboard (NRD=2 main instance, NRD=3 side instance).
module tb_decode_grf_scoreboard;
    import decode_grf_scoreboard_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] stall_cnt;
    logic [31:0] stall_cnt3;
    int          checks;
    int          failures;

    decode_grf_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .NRD(2), .TNEW_W(2)) bus  ();
    decode_grf_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .NRD(3), .TNEW_W(2)) bus3 ();

    decode_grf_scoreboard #(.DATA_W(32), .ADDR_W(5), .NRD(2), .TNEW_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .stall_cnt (stall_cnt)
    );

    decode_grf_scoreboard #(.DATA_W(32), .ADDR_W(5), .NRD(3), .TNEW_W(2)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus3.slave),
        .stall_cnt (stall_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        bus.rd_addr     = '0;
        bus.rd_tuse     = '0;
        bus.issue_valid = 1'b0;
        bus.issue_dst   = '0;
        bus.issue_tnew  = '0;
        bus.wb_we       = 1'b0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;
        bus.wb_pc       = 32'h0000_3000;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [1:0] t0,
                      input logic [4:0] a1, input logic [1:0] t1);
        bus.rd_addr = {a1, a0};
        bus.rd_tuse = {t1, t0};
    endtask

    task automatic issue(input logic v, input logic [4:0] dst, input logic [1:0] tnew);
        bus.issue_valid = v;
        bus.issue_dst   = dst;
        bus.issue_tnew  = tnew;
    endtask

    task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
        bus.wb_we   = we;
        bus.wb_addr = a;
        bus.wb_data = d;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle();
        bus3.rd_addr     = '0;
        bus3.rd_tuse     = '0;
        bus3.issue_valid = 1'b0;
        bus3.issue_dst   = '0;
        bus3.issue_tnew  = '0;
        bus3.wb_we       = 1'b0;
        bus3.wb_addr     = '0;
        bus3.wb_data     = '0;
        bus3.wb_pc       = '0;

        // 1: reset two cycles, then everything reads 0
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        rd(5'd5, T_NOW, 5'd31, T_NOW);
        settle();
        check("reset_rd5",    bus.rd_data[31:0],  32'h0);
        check("reset_rd31",   bus.rd_data[63:32], 32'h0);
        check("reset_stall",  {31'd0, bus.stall}, 32'd0);
        check("reset_scnt",   stall_cnt,          32'd0);

        // 2: write-through bypass, stored value, writes to 0 dropped
        wb(1'b1, 5'd8, 32'h1234_5678);
        rd(5'd8, T_NOW, 5'd0, T_NOW);
        settle();
        check("bypass_rd8",   bus.rd_data[31:0],  32'h1234_5678);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        rd(5'd8, T_NOW, 5'd8, T_NOW);
        settle();
        check("stored_rd8_p0", bus.rd_data[31:0],  32'h1234_5678);
        check("stored_rd8_p1", bus.rd_data[63:32], 32'h1234_5678);
        wb(1'b1, 5'd0, 32'hFFFF_FFFF);
        rd(5'd0, T_NOW, 5'd8, T_NOW);
        settle();
        check("wr0_bypass",   bus.rd_data[31:0],  32'h0);
        tick();
        wb(1'b1, 5'd31, 32'hA5A5_5A5A);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        rd(5'd0, T_NOW, 5'd31, T_NOW);
        settle();
        check("wr0_stored",   bus.rd_data[31:0],  32'h0);
        check("rd31",         bus.rd_data[63:32], 32'hA5A5_5A5A);

        // 3: tnew=2 vs tuse=0 stalls two cycles, vs tuse=1 one cycle
        rd(5'd0, T_NOW, 5'd0, T_NOW);
        issue(1'b1, 5'd9, T_2);
        settle();
        check("issue_nostall", {31'd0, bus.stall}, 32'd0);
        tick();
        issue(1'b0, 5'd0, T_NOW);
        rd(5'd9, T_NOW, 5'd0, T_NOW);
        settle();
        check("haz_cnt2",     {31'd0, bus.stall}, 32'd1);
        tick();
        check("haz_cnt1",     {31'd0, bus.stall}, 32'd1);
        tick();
        check("haz_cnt0",     {31'd0, bus.stall}, 32'd0);
        check("scnt_2",       stall_cnt,          32'd2);
        rd(5'd0, T_NOW, 5'd0, T_NOW);
        issue(1'b1, 5'd9, T_2);
        tick();
        issue(1'b0, 5'd0, T_NOW);
        rd(5'd9, T_1, 5'd0, T_NOW);
        settle();
        check("tuse1_cnt2",   {31'd0, bus.stall}, 32'd1);
        tick();
        check("tuse1_cnt1",   {31'd0, bus.stall}, 32'd0);
        check("scnt_3",       stall_cnt,          32'd3);
        tick();

        // 4: stalled issue ignored (tnew 3 would be visible), unstalled re-issue overrides
        rd(5'd0, T_NOW, 5'd0, T_NOW);
        issue(1'b1, 5'd9, T_2);
        tick();
        rd(5'd9, T_NOW, 5'd0, T_NOW);
        issue(1'b1, 5'd9, T_3);
        settle();
        check("stalled_issue", {31'd0, bus.stall}, 32'd1);
        tick();
        issue(1'b0, 5'd0, T_NOW);
        settle();
        check("ign_cnt_gt0",  {31'd0, bus.stall}, 32'd1);
        rd(5'd9, T_1, 5'd0, T_NOW);
        settle();
        check("ign_cnt_le1",  {31'd0, bus.stall}, 32'd0);
        rd(5'd0, T_NOW, 5'd0, T_NOW);
        issue(1'b1, 5'd9, T_2);
        tick();
        issue(1'b1, 5'd9, T_1);
        tick();
        issue(1'b0, 5'd0, T_NOW);
        rd(5'd9, T_NOW, 5'd0, T_NOW);
        settle();
        check("reissue_gt0",  {31'd0, bus.stall}, 32'd1);
        rd(5'd9, T_1, 5'd0, T_NOW);
        settle();
        check("reissue_le1",  {31'd0, bus.stall}, 32'd0);
        // cnt[9]=1 here: an override to 3 must beat the decrement to 0
        rd(5'd0, T_NOW, 5'd0, T_NOW);
        issue(1'b1, 5'd9, T_3);
        tick();
        issue(1'b0, 5'd0, T_NOW);
        rd(5'd9, T_2, 5'd0, T_NOW);
        settle();
        check("override_gt2", {31'd0, bus.stall}, 32'd1);
        rd(5'd0, T_NOW, 5'd9, T_3);
        settle();
        check("override_le3", {31'd0, bus.stall}, 32'd0);
        rd(5'd0, T_NOW, 5'd0, T_NOW);
        tick();
        tick();
        tick();
        check("scnt_4",       stall_cnt,          32'd4);

        // boundary: tnew=0 and dst=0 never hazard
        issue(1'b1, 5'd11, T_NOW);
        tick();
        issue(1'b1, 5'd0, T_3);
        rd(5'd11, T_NOW, 5'd0, T_NOW);
        settle();
        check("tnew0",        {31'd0, bus.stall}, 32'd0);
        tick();
        issue(1'b0, 5'd0, T_NOW);
        rd(5'd0, T_NOW, 5'd11, T_NOW);
        settle();
        check("dst0",         {31'd0, bus.stall}, 32'd0);

        // 5: three read ports, only port 2 hazards
        bus3.issue_valid = 1'b1;
        bus3.issue_dst   = 5'd10;
        bus3.issue_tnew  = T_1;
        tick();
        bus3.issue_valid = 1'b0;
        bus3.rd_addr     = {5'd10, 5'd9, 5'd9};
        bus3.rd_tuse     = {T_NOW, T_NOW, T_NOW};
        settle();
        check("nrd3_stall",   {31'd0, bus3.stall}, 32'd1);
        bus3.rd_tuse     = {T_1, T_NOW, T_NOW};
        settle();
        check("nrd3_tuse1",   {31'd0, bus3.stall}, 32'd0);
        check("nrd3_scnt",    stall_cnt3,          32'd0);
        bus3.rd_addr     = '0;
        bus3.rd_tuse     = '0;
        tick();

        // 6: reset with a pending counter, an active stall and a concurrent write
        rd(5'd0, T_NOW, 5'd0, T_NOW);
        issue(1'b1, 5'd9, T_2);
        tick();
        issue(1'b0, 5'd0, T_NOW);
        rd(5'd9, T_NOW, 5'd0, T_NOW);
        wb(1'b1, 5'd20, 32'hDEAD_BEEF);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        wb(1'b0, 5'd0, 32'h0);
        rd(5'd9, T_NOW, 5'd8, T_NOW);
        settle();
        check("rst_stall",    {31'd0, bus.stall}, 32'd0);
        check("rst_scnt",     stall_cnt,          32'd0);
        check("rst_reg8",     bus.rd_data[63:32], 32'h0);
        rd(5'd20, T_NOW, 5'd31, T_NOW);
        settle();
        check("rst_reg20",    bus.rd_data[31:0],  32'h0);
        check("rst_reg31",    bus.rd_data[63:32], 32'h0);
        tick();
        check("rst_scnt_hold", stall_cnt,         32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
